scan_display_mux: RTL and testbench

//  Parametrised time-multiplexed driver for an N-digit common-cathode 7-segment display.

---
 rtl/scan_display_mux.sv | 173 +++++++++++++++++
 tb/tb_scan_display_mux.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_display_mux.sv
// Time-multiplexed N-digit common-cathode 7-segment driver with dead time, PWM
// brightness, per-digit blanking, decimal points, leading-zero suppression and frame snapshots.
module scan_display_mux #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_HZ   = 400,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BRIGHT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lzs_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int unsigned SLOT_CYC = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
  localparam int unsigned ACTIVE   = SLOT_CYC - BLANK_CYCLES;
  localparam int unsigned CNT_W    = $clog2(SLOT_CYC);
  localparam int unsigned IDX_W    = $clog2(NUM_DIGITS);
  localparam int unsigned PWM_W    = CNT_W + BRIGHT_W;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  generate
    if (SLOT_CYC <= BLANK_CYCLES + 1) begin : g_bad_timing
      $error("scan_display_mux: digit slot too short for the requested dead time");
    end
    if (NUM_DIGITS < 2 || BLANK_CYCLES < 1) begin : g_bad_params
      $error("scan_display_mux: NUM_DIGITS must be >= 2 and BLANK_CYCLES >= 1");
    end
  endgenerate

  logic [1:0]              state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    load;

  logic [4*NUM_DIGITS-1:0] value_s;
  logic [NUM_DIGITS-1:0]   dp_s;
  logic [NUM_DIGITS-1:0]   blank_s;
  logic                    lzs_s;
  logic [BRIGHT_W-1:0]     bright_s;

  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   zero_up;
  logic [NUM_DIGITS-1:0]   supp;
  logic                    pwm_on;
  logic                    lit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h7E;  4'h1: hex7 = 7'h30;  4'h2: hex7 = 7'h6D;  4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33;  4'h5: hex7 = 7'h5B;  4'h6: hex7 = 7'h5F;  4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h7B;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E;  4'hD: hex7 = 7'h3D;  4'hE: hex7 = 7'h4F;  default: hex7 = 7'h47;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOAD;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state: load slot, then per digit a dead-time phase followed by a drive phase
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    load      = 1'b0;
    case (state)
      S_LOAD: begin
        load      = 1'b1;
        idx_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = S_BLANK;
      end
      S_BLANK: begin
        if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_DRIVE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DRIVE: begin
        if (cnt == CNT_W'(ACTIVE - 1)) begin
          cnt_nxt = '0;
          if (idx == IDX_W'(NUM_DIGITS - 1)) begin
            state_nxt = S_LOAD;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = S_BLANK;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_LOAD;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // Frame snapshot, so a frame never mixes old and new input values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_s  <= '0;
      dp_s     <= '0;
      blank_s  <= '0;
      lzs_s    <= 1'b0;
      bright_s <= '0;
    end else if (load) begin
      value_s  <= value;
      dp_s     <= dp_in;
      blank_s  <= blank_mask;
      lzs_s    <= lzs_en;
      bright_s <= brightness;
    end
  end

  // zero_up[i]: nibbles i..NUM_DIGITS-1 of the snapshot are all zero
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = value_s[4*i +: 4];
    end
    zero_up = '0;
    zero_up[NUM_DIGITS-1] = (nib[NUM_DIGITS-1] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_up[i] = zero_up[i+1] && (nib[i] == 4'h0);
    end
    supp = lzs_s ? (zero_up & ~NUM_DIGITS'(1)) : '0;
  end

  // Outputs are decided from the upcoming state so they line up with the state register
  always_comb begin
    pwm_on = ((PWM_W'(cnt_nxt) << BRIGHT_W) < (PWM_W'(bright_s) * PWM_W'(ACTIVE)));
    lit    = (state_nxt == S_DRIVE) && pwm_on && !blank_s[idx_nxt] && !supp[idx_nxt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg         <= '0;
      dp          <= 1'b0;
      digit_en    <= '0;
      frame_start <= 1'b0;
    end else begin
      seg         <= lit ? hex7(nib[idx_nxt]) : 7'h00;
      dp          <= lit && dp_s[idx_nxt];
      digit_en    <= lit ? (NUM_DIGITS'(1) << idx_nxt) : '0;
      frame_start <= (state == S_LOAD);
    end
  end

endmodule

// File: tb/tb_scan_display_mux.sv
// Scoreboarded random bench for scan_display_mux: stimulus queues per-frame configs,
// a monitor checks every output cycle of each frame against a slot-level reference model.
module tb_scan_display_mux;

  localparam int unsigned ND     = 4;
  localparam int unsigned BW     = 2;
  localparam int unsigned SLOT   = 8;
  localparam int unsigned BLANK  = 2;
  localparam int unsigned ACTIVE = 6;
  localparam int unsigned FRAME  = ND * SLOT + 1;
  localparam int unsigned NF     = 16;
  localparam int unsigned NDIR   = 7;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lzs;
    logic [1:0]  bright;
  } cfg_t;

  logic          clk;
  logic          rst;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic [3:0]    blank_mask;
  logic          lzs_en;
  logic [1:0]    brightness;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    digit_en;
  logic          frame_start;

  cfg_t          q[$];
  cfg_t          dir [NDIR];
  cfg_t          last_cfg;
  int            checks = 0;
  int            errors = 0;
  logic [6:0]    hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  scan_display_mux #(
    .CLK_FREQ(3200), .NUM_DIGITS(ND), .REFRESH_HZ(100), .BLANK_CYCLES(BLANK), .BRIGHT_W(BW)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_mask(blank_mask),
    .lzs_en(lzs_en), .brightness(brightness), .seg(seg), .dp(dp), .digit_en(digit_en),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: frame cycle t counts from the frame_start pulse; the last cycle is the load slot
  function automatic logic [12:0] expect_at(cfg_t c, int t);
    int   slot, off, nlit;
    logic on;
    logic [3:0] nb;
    if (t >= int'(ND * SLOT)) return 13'h0;
    slot = t / int'(SLOT);
    off  = t % int'(SLOT);
    nlit = (int'(c.bright) * int'(ACTIVE) + (1 << BW) - 1) >> BW;
    if (nlit > int'(ACTIVE)) nlit = int'(ACTIVE);
    nb = 4'(c.value >> (4 * slot));
    on = (off >= int'(BLANK)) && ((off - int'(BLANK)) < nlit) && !c.blank[slot]
         && !(c.lzs && slot > 0 && (c.value >> (4 * slot)) == 16'h0);
    return {t == 0, on ? 4'(1 << slot) : 4'b0, on && c.dp[slot], on ? hex_tab[nb] : 7'h0};
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.value  = 16'($urandom) >> (4 * $urandom_range(0, 3));
    c.dp     = 4'($urandom);
    c.blank  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
    c.lzs    = 1'($urandom_range(0, 1));
    c.bright = 2'($urandom);
    return c;
  endfunction

  task automatic check(input string name, input int t, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got {fs,en,dp,seg}=%h expected %h", name, t, got, exp);
    end
  endtask

  task automatic apply(input cfg_t c);
    value      = c.value;
    dp_in      = c.dp;
    blank_mask = c.blank;
    lzs_en     = c.lzs;
    brightness = c.bright;
    q.push_back(c);
  endtask

  task automatic wait_fs(output int waited, output bit ok);
    waited = 0;
    ok     = 1'b0;
    for (int i = 0; i < 3 * int'(FRAME); i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
  endtask

  task automatic stimulus();
    int   waited;
    bit   ok;
    cfg_t c;
    for (int f = 1; f <= int'(NF); f++) begin
      wait_fs(waited, ok);
      if (!ok) return;
      if (f == int'(NF))      c = last_cfg;
      else if (f < int'(NDIR)) c = dir[f];
      else                    c = rand_cfg();
      repeat ((f < int'(NDIR)) ? 10 : $urandom_range(1, 30)) @(negedge clk);
      apply(c);
    end
  endtask

  task automatic monitor();
    int   waited;
    bit   ok;
    cfg_t c;
    for (int f = 1; f <= int'(NF); f++) begin
      wait_fs(waited, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL frame_start_timeout frame=%0d got no pulse expected one", f);
        return;
      end
      if (waited != 0) begin
        errors++;
        $display("FAIL frame_period frame=%0d got %0d extra cycles expected 0", f, waited);
      end
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty frame=%0d got empty queue expected a config", f);
        return;
      end
      c = q.pop_front();
      for (int t = 0; t < int'(FRAME); t++) begin
        if (t > 0) @(negedge clk);
        check($sformatf("frame%0d_out", f), t, {frame_start, digit_en, dp, seg}, expect_at(c, t));
      end
    end
  endtask

  initial begin
    int waited;
    bit ok;
    dir[0]   = '{value: 16'h12AF, dp: 4'b0000, blank: 4'b0000, lzs: 1'b0, bright: 2'd3};
    dir[1]   = '{value: 16'hFFFF, dp: 4'b0000, blank: 4'b0000, lzs: 1'b0, bright: 2'd3};
    dir[2]   = '{value: 16'h0030, dp: 4'b0000, blank: 4'b0000, lzs: 1'b1, bright: 2'd3};
    dir[3]   = '{value: 16'h0000, dp: 4'b0000, blank: 4'b0000, lzs: 1'b1, bright: 2'd3};
    dir[4]   = '{value: 16'h12AF, dp: 4'b1111, blank: 4'b0000, lzs: 1'b0, bright: 2'd0};
    dir[5]   = '{value: 16'h12AF, dp: 4'b0000, blank: 4'b0000, lzs: 1'b0, bright: 2'd1};
    dir[6]   = '{value: 16'h5678, dp: 4'b0001, blank: 4'b0100, lzs: 1'b0, bright: 2'd3};
    last_cfg = '{value: 16'h1234, dp: 4'b0000, blank: 4'b0000, lzs: 1'b0, bright: 2'd3};

    rst = 1'b1;
    apply(dir[0]);
    repeat (2) @(negedge clk);
    check("reset_state", 0, {frame_start, digit_en, dp, seg}, 13'h0);
    rst = 1'b0;

    fork
      stimulus();
      monitor();
    join

    // Asynchronous reset while digit 2 is being driven
    wait_fs(waited, ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL reset_test_sync got no frame_start expected one");
    end else begin
      repeat (2 * SLOT + BLANK + 1) @(negedge clk);
      check("pre_reset_drive", 19, {frame_start, digit_en, dp, seg}, {1'b0, 4'b0100, 1'b0, 7'h6D});
      #1 rst = 1'b1;
      #1 check("async_clear", 19, {frame_start, digit_en, dp, seg}, 13'h0);
      repeat (3) @(negedge clk);
      check("held_in_reset", 0, {frame_start, digit_en, dp, seg}, 13'h0);
      rst = 1'b0;
      @(negedge clk);
      check("first_after_release", 0, {frame_start, digit_en, dp, seg}, {1'b1, 4'b0000, 1'b0, 7'h00});
      repeat (BLANK) @(negedge clk);
      check("first_digit_after_release", 2, {frame_start, digit_en, dp, seg}, {1'b0, 4'b0001, 1'b0, 7'h33});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
